// File: rtl/shift_reg_piso_if.sv
// Load handshake and serial output bundle for the parallel-in/serial-out shifter.
interface shift_reg_piso_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;
    logic             shift_en;
    logic             data_out;
    logic             out_valid;
    logic             frame_start;
    logic             frame_end;

    // Producer side: supplies words and the shift enable, observes the serial stream.
    modport master (
        output data_in, load_valid, shift_en,
        input  load_ready, data_out, out_valid, frame_start, frame_end
    );

    // Shifter side.
    modport slave (
        input  data_in, load_valid, shift_en,
        output load_ready, data_out, out_valid, frame_start, frame_end
    );
endinterface

// File: rtl/shift_reg_piso.sv
// Parallel-in, serial-out shift register with valid/ready load and frame strobes.
// The word is held in a register that is shifted toward the emit end, so the
// next bit is always at a fixed position; back-to-back loads on the last bit
// give a gap-free stream.
module shift_reg_piso #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    shift_reg_piso_if.slave       bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             dout_q,  dout_d;
    logic             ov_q,    ov_d;
    logic             fs_q,    fs_d;
    logic             fe_q,    fe_d;
    logic             last;
    logic             load;
    logic [WIDTH-1:0] shifted;

    // Bit at the emit end of a word.
    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    assign last    = (state_q == SHIFT) && (cnt_q == LAST);
    assign shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};

    // Ready in IDLE, or on the last bit when that bit is actually leaving this edge.
    assign bus.load_ready = !reset && ((state_q == IDLE) || (last && bus.shift_en));
    assign load           = bus.load_valid && bus.load_ready;

    // Registered state and outputs; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            ov_q    <= 1'b0;
            fs_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            ov_q    <= ov_d;
            fs_q    <= fs_d;
            fe_q    <= fe_d;
        end
    end

    // Next state: load wins, otherwise advance on shift_en; default is a full hold (stall).
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        ov_d    = ov_q;
        fs_d    = fs_q;
        fe_d    = fe_q;
        if (load) begin
            state_d = SHIFT;
            shreg_d = bus.data_in;
            cnt_d   = '0;
            dout_d  = head(bus.data_in);
            ov_d    = 1'b1;
            fs_d    = 1'b1;
            fe_d    = 1'b0;
        end else if (state_q == SHIFT && bus.shift_en) begin
            if (last) begin
                state_d = IDLE;
                shreg_d = '0;
                cnt_d   = '0;
                dout_d  = 1'b0;
                ov_d    = 1'b0;
                fs_d    = 1'b0;
                fe_d    = 1'b0;
            end else begin
                shreg_d = shifted;
                cnt_d   = cnt_q + CW'(1);
                dout_d  = head(shifted);
                fs_d    = 1'b0;
                fe_d    = ((cnt_q + CW'(1)) == LAST);
            end
        end
    end

    assign bus.data_out    = dout_q;
    assign bus.out_valid   = ov_q;
    assign bus.frame_start = fs_q;
    assign bus.frame_end   = fe_q;
endmodule

// File: tb/tb_shift_reg_piso.sv
// Directed bench for shift_reg_piso: one MSB-first and one LSB-first instance
// driven with identical stimulus, plus a 4-bit serial-in register on the
// MSB-first output for the loopback check.
module tb_shift_reg_piso;
    logic clk;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [3:0] sipo;
    logic [3:0] mb, lb;
    logic [7:0] mb8, lb8;

    shift_reg_piso_if #(.WIDTH(4)) if_m ();
    shift_reg_piso_if #(.WIDTH(4)) if_l ();

    shift_reg_piso #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .reset(reset), .bus(if_m));
    shift_reg_piso #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .reset(reset), .bus(if_l));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Receiving serial-in register, shifting every clock, MSB first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sipo <= '0;
        else       sipo <= {sipo[2:0], if_m.data_out};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic lv, input logic [3:0] d, input logic se);
        if_m.load_valid = lv; if_m.data_in = d; if_m.shift_en = se;
        if_l.load_valid = lv; if_l.data_in = d; if_l.shift_en = se;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks both instances: serial bits per instance, shared strobes/ready.
    task automatic chk_out(input string tag, input logic dm, input logic dl, input logic ov,
                           input logic fs, input logic fe, input logic lr);
        chk(tag,
            {22'd0, if_m.data_out, if_l.data_out,
             if_m.out_valid, if_m.frame_start, if_m.frame_end, if_m.load_ready,
             if_l.out_valid, if_l.frame_start, if_l.frame_end, if_l.load_ready},
            {22'd0, dm, dl, ov, fs, fe, lr, ov, fs, fe, lr});
    endtask

    initial begin
        reset = 1'b1;
        drv(1'b0, 4'h0, 1'b1);
        #2;
        chk_out("reset", 0, 0, 0, 0, 0, 0);
        tick(); tick();
        reset = 1'b0;
        #1;
        chk_out("idle_after_reset", 0, 0, 0, 0, 0, 1);

        // 1/2: 1011 from IDLE, both bit orders
        mb = 4'b1011; lb = 4'b1101;
        drv(1'b1, 4'b1011, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk_out($sformatf("t1_bit%0d", i), mb[3-i], lb[3-i], 1, i == 0, i == 3, i == 3);
            drv(1'b0, 4'b1011, 1'b1);
            tick();
        end
        chk_out("t1_idle", 0, 0, 0, 0, 0, 1);

        // 3: back-to-back A then 5, load_valid held through the first frame
        mb8 = 8'b1010_0101; lb8 = 8'b0101_1010;
        drv(1'b1, 4'hA, 1'b1);
        tick();
        for (int i = 0; i < 8; i++) begin
            chk_out($sformatf("t3_bit%0d", i), mb8[7-i], lb8[7-i], 1,
                    (i == 0) || (i == 4), (i == 3) || (i == 7), (i == 3) || (i == 7));
            drv(i < 4, 4'h5, 1'b1);
            tick();
        end
        chk_out("t3_idle", 0, 0, 0, 0, 0, 1);

        // 4: stall on bit 2 and on the last bit
        drv(1'b1, 4'b1100, 1'b1);
        tick();
        chk_out("t4_bit0", 1, 0, 1, 1, 0, 0);
        drv(1'b0, 4'b1100, 1'b1);
        tick();
        chk_out("t4_bit1", 1, 0, 1, 0, 0, 0);
        drv(1'b0, 4'b1100, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out($sformatf("t4_stall%0d", i), 1, 0, 1, 0, 0, 0);
        end
        drv(1'b0, 4'b1100, 1'b1);
        tick();
        chk_out("t4_bit2", 0, 1, 1, 0, 0, 0);
        tick();
        chk_out("t4_bit3", 0, 1, 1, 0, 1, 1);
        drv(1'b0, 4'b1100, 1'b0);
        #1;
        chk_out("t4_end_stall_now", 0, 1, 1, 0, 1, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_out($sformatf("t4_end_stall%0d", i), 0, 1, 1, 0, 1, 0);
        end
        drv(1'b0, 4'b1100, 1'b1);
        tick();
        chk_out("t4_idle", 0, 0, 0, 0, 0, 1);

        // 5: asynchronous reset mid-frame, then a clean frame
        drv(1'b1, 4'b1111, 1'b1);
        tick();
        drv(1'b0, 4'b1111, 1'b1);
        tick();
        chk_out("t5_bit1", 1, 1, 1, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        chk_out("t5_reset_now", 0, 0, 0, 0, 0, 0);
        tick();
        chk_out("t5_reset_held", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        #1;
        chk_out("t5_release", 0, 0, 0, 0, 0, 1);
        mb = 4'b0001; lb = 4'b1000;
        drv(1'b1, 4'b0001, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk_out($sformatf("t5_bit%0d", i), mb[3-i], lb[3-i], 1, i == 0, i == 3, i == 3);
            drv(1'b0, 4'b0001, 1'b1);
            tick();
        end
        chk_out("t5_idle", 0, 0, 0, 0, 0, 1);

        // 6: loopback into the serial-in register
        drv(1'b1, 4'b1011, 1'b1);
        tick();
        drv(1'b0, 4'b1011, 1'b1);
        tick(); tick(); tick();
        chk("t6_frame_end", {31'd0, if_m.frame_end}, 32'd1);
        tick();
        chk("t6_loopback", {28'd0, sipo}, 32'h0000_000B);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
